// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: glyph table (active-high, bit 6 = a .. bit 0 = g)
// and the inversion mask used for active-low outputs.
package sseg_pkg;

  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  localparam logic [7:0] SEG_INV_MASK = 8'hFF;

endpackage

// File: rtl/sseg_hex_enc.sv
// Combinational hex digit to active-high a..g glyph encoder.
module sseg_hex_enc
  import sseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = GLYPH_TBL[hex];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with PWM brightness, blink,
// leading-zero suppression and frame-synchronous double-buffered digit data.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned BLINK_W    = 24,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_blank,
  input  logic [3:0]              bright,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    frame_done
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_MASK  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0]            SEG_MASK = (ACTIVE_LOW != 0) ? SEG_INV_MASK : 8'h00;

  logic [DIV_W-1:0]        pre;
  logic [IDX_W-1:0]        idx;
  logic [BLINK_W-1:0]      blink_cnt;
  logic [3:0]              bright_q;

  logic [4*NUM_DIGITS-1:0] pend_hex, act_hex;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [NUM_DIGITS-1:0]   pend_blank, act_blank;
  logic [NUM_DIGITS-1:0]   pend_blink, act_blink;

  logic                    tick, wrap;
  logic [3:0]              cur_hex;
  logic [6:0]              cur_glyph;
  logic [NUM_DIGITS-1:0]   lz_vec;
  logic                    zero_tail;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_c;
  logic [7:0]              sseg_c;

  assign tick = &pre;
  assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

  // Digit i>0 is a leading zero when it and every higher digit are 0 with no dp.
  always_comb begin
    zero_tail = 1'b1;
    lz_vec    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_tail = zero_tail && (act_hex[4*i +: 4] == 4'h0) && !act_dp[i];
      if (i > 0) lz_vec[i] = zero_tail;
    end
  end

  assign cur_hex = act_hex[{idx, 2'b00} +: 4];

  sseg_hex_enc u_enc (
    .hex (cur_hex),
    .seg (cur_glyph)
  );

  always_comb begin
    lit    = (pre[DIV_W-1 -: 4] <= bright_q)
          && !act_blank[idx]
          && !(lz_blank && lz_vec[idx])
          && !(blink_cnt[BLINK_W-1] && act_blink[idx]);
    an_c   = AN_MASK;
    sseg_c = SEG_MASK;
    if (lit) begin
      an_c   = (NUM_DIGITS'(1) << idx) ^ AN_MASK;
      sseg_c = {act_dp[idx], cur_glyph} ^ SEG_MASK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre        <= '0;
      idx        <= '0;
      blink_cnt  <= '0;
      bright_q   <= '0;
      pend_hex   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_blink <= '0;
      act_hex    <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      act_blink  <= '0;
      an         <= AN_MASK;
      sseg       <= SEG_MASK;
      frame_done <= 1'b0;
    end else begin
      pre       <= pre + DIV_W'(1);
      blink_cnt <= blink_cnt + BLINK_W'(1);
      if (tick) begin
        bright_q <= bright;
        idx      <= wrap ? '0 : idx + IDX_W'(1);
      end
      if (load) begin
        pend_hex   <= hex_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_blink <= blink_en;
      end
      // A load landing on the boundary bypasses the pending stage.
      if (wrap) begin
        act_hex   <= load ? hex_in   : pend_hex;
        act_dp    <= load ? dp_in    : pend_dp;
        act_blank <= load ? blank_in : pend_blank;
        act_blink <= load ? blink_en : pend_blink;
      end
      an         <= an_c;
      sseg       <= sseg_c;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomized bench for sseg_scan_ctrl with a cycle-count based reference model
// plus directed literal checks of the display sequence.
module tb_sseg_scan_ctrl;

  localparam logic [6:0] GLYPH_REF [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hex_in;
  logic [3:0]  dp_in, blank_in, blink_en;
  logic        lz_blank;
  logic [3:0]  bright;
  logic        load;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  // model state: k = clock edges since reset release
  int          k;
  logic [15:0] p_hex, a_hex;
  logic [3:0]  p_dp, a_dp, p_bl, a_bl, p_bk, a_bk;
  logic [3:0]  m_bright;
  logic [3:0]  exp_an;
  logic [7:0]  exp_sseg;
  logic        exp_fd;

  sseg_scan_ctrl #(
    .NUM_DIGITS (4),
    .DIV_W      (5),
    .BLINK_W    (8),
    .ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .blink_en   (blink_en),
    .lz_blank   (lz_blank),
    .bright     (bright),
    .load       (load),
    .an         (an),
    .sseg       (sseg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Expected outputs after edge k, then advance the model across that edge.
  task automatic model_edge();
    int   pre_v, d;
    logic on, zt;
    pre_v = k % 32;
    d     = (k / 32) % 4;
    on    = ((pre_v / 2) <= int'(m_bright));
    if (a_bl[d]) on = 1'b0;
    if (a_bk[d] && ((k / 128) % 2 == 1)) on = 1'b0;
    if (lz_blank && d > 0) begin
      zt = 1'b1;
      for (int j = d; j < 4; j++)
        if (a_hex[4*j +: 4] != 4'h0 || a_dp[j]) zt = 1'b0;
      if (zt) on = 1'b0;
    end
    exp_an   = on ? ~(4'b0001 << d) : 4'hF;
    exp_sseg = on ? ~{a_dp[d], GLYPH_REF[a_hex[4*d +: 4]]} : 8'hFF;
    exp_fd   = (k % 128 == 127);
    if (k % 32 == 31) m_bright = bright;
    if (k % 128 == 127) begin
      a_hex = load ? hex_in   : p_hex;
      a_dp  = load ? dp_in    : p_dp;
      a_bl  = load ? blank_in : p_bl;
      a_bk  = load ? blink_en : p_bk;
    end
    if (load) begin
      p_hex = hex_in; p_dp = dp_in; p_bl = blank_in; p_bk = blink_en;
    end
    k++;
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_to(input int e);
    while (k <= e) tick();
  endtask

  task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, req, k - 1);
    end
  endtask

  task automatic apply_reset(input int hold);
    reset = 1'b1;
    load  = 1'b0;
    k = 0; m_bright = '0;
    p_hex = '0; a_hex = '0; p_dp = '0; a_dp = '0;
    p_bl = '0; a_bl = '0; p_bk = '0; a_bk = '0;
    exp_an = 4'hF; exp_sseg = 8'hFF; exp_fd = 1'b0;
    #1;
    check_lit("reset_an", {4'h0, an}, 8'h0F);
    check_lit("reset_sseg", sseg, 8'hFF);
    check_lit("reset_fd", {7'h0, frame_done}, 8'h00);
    repeat (hold) @(negedge clk);
    reset = 1'b0;
  endtask

  // Compare every cycle, well after the active edge.
  always @(posedge clk) begin
    #2;
    n_vec++;
    if (an !== exp_an || sseg !== exp_sseg || frame_done !== exp_fd || $countones(~an) > 1) begin
      n_err++;
      $display("FAIL cycle edge %0d: an=%b sseg=%h fd=%b, expected an=%b sseg=%h fd=%b",
               k - 1, an, sseg, frame_done, exp_an, exp_sseg, exp_fd);
    end
  end

  initial begin
    hex_in = '0; dp_in = '0; blank_in = '0; blink_en = '0;
    lz_blank = 1'b0; bright = 4'd15; load = 1'b0;
    apply_reset(3);

    // basic scan with 0x1238 at full brightness
    hex_in = 16'h1238; load = 1'b1; tick(); load = 1'b0;
    run_to(128); check_lit("d0_an", {4'h0, an}, 8'h0E); check_lit("d0_glyph8", sseg, 8'h80);
    run_to(224); check_lit("d3_an", {4'h0, an}, 8'h07); check_lit("d3_glyph1", sseg, 8'hCF);
    run_to(255); check_lit("frame_pulse", {7'h0, frame_done}, 8'h01);
    run_to(256); check_lit("frame_one_cycle", {7'h0, frame_done}, 8'h00);

    // dim brightness: lit for 8 of 32 cycles
    bright = 4'd3;
    run_to(295); check_lit("pwm_lit_an", {4'h0, an}, 8'h0D); check_lit("pwm_lit_sseg", sseg, 8'h86);
    run_to(296); check_lit("pwm_off_an", {4'h0, an}, 8'h0F); check_lit("pwm_off_sseg", sseg, 8'hFF);

    // leading-zero suppression
    bright = 4'd15; lz_blank = 1'b1;
    run_to(299); hex_in = 16'h0050; load = 1'b1; tick(); load = 1'b0;
    run_to(384); check_lit("lz_d0", sseg, 8'h81);
    run_to(416); check_lit("lz_d1", sseg, 8'hA4);
    run_to(448); check_lit("lz_d2_dark", {4'h0, an}, 8'h0F);
    run_to(480); check_lit("lz_d3_dark", {4'h0, an}, 8'h0F);
    dp_in = 4'b1000; load = 1'b1; tick(); load = 1'b0;
    run_to(576); check_lit("lz_dp_d2", {4'h0, an}, 8'h0B); check_lit("lz_dp_d2_sseg", sseg, 8'h81);
    run_to(608); check_lit("lz_dp_d3", {4'h0, an}, 8'h07); check_lit("lz_dp_d3_sseg", sseg, 8'h01);

    // mid-frame load waits for the boundary; boundary load is immediate
    lz_blank = 1'b0; dp_in = 4'b0000; hex_in = 16'hAAAA; load = 1'b1; tick(); load = 1'b0;
    run_to(620); check_lit("midframe_hold", sseg, 8'h01);
    run_to(640); check_lit("midframe_apply", sseg, 8'h88);
    while (k % 128 != 127) tick();
    hex_in = 16'h7777; load = 1'b1; tick(); load = 1'b0; tick();
    check_lit("boundary_load_an", {4'h0, an}, 8'h0E);
    check_lit("boundary_load_sseg", sseg, 8'h8F);

    // blink on digit 0
    blink_en = 4'b0001; load = 1'b1; tick(); load = 1'b0;
    repeat (600) tick();

    // randomized phase
    for (int c = 0; c < 2500; c++) begin
      load = ($urandom_range(0, 31) == 0) || ((k % 128 == 127) && ($urandom_range(0, 1) == 1));
      if (load) begin
        hex_in   = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom());
        dp_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
        blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
        blink_en = 4'($urandom());
      end
      if ($urandom_range(0, 63) == 0) bright = 4'($urandom());
      if ($urandom_range(0, 127) == 0) lz_blank = ~lz_blank;
      tick();
    end
    load = 1'b0;

    // reset at idx 2 discards a pending load
    dp_in = '0; blank_in = '0; blink_en = '0; lz_blank = 1'b0; bright = 4'd15;
    while (!((k / 32) % 4 == 2 && k % 32 == 10)) tick();
    hex_in = 16'h5555; load = 1'b1; tick(); load = 1'b0;
    repeat (3) tick();
    apply_reset(2);
    tick(); check_lit("post_reset_an", {4'h0, an}, 8'h0E); check_lit("post_reset_sseg", sseg, 8'h81);
    tick(); tick(); check_lit("post_reset_dim", {4'h0, an}, 8'h0F);
    repeat (300) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 Parameter DIV_W, default 16, refresh prescaler width in bits (>=5); one digit slot lasts 2^DIV_W cycles.
REQ-003 Parameter BLINK_W, default 24, blink counter width in bits; blink period is 2^BLINK_W cycles.
REQ-004 Parameter ACTIVE_LOW, default 1; 1 means `an` and `sseg` are asserted low, 0 means asserted high.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 hex_in  in  4*NUM_DIGITS  digit values; digit i occupies bits [4i+3:4i].
REQ-008 dp_in  in  NUM_DIGITS  decimal point per digit; 1 means lit.
REQ-009 blank_in  in  NUM_DIGITS  forced blank per digit; 1 means dark.
REQ-010 blink_en  in  NUM_DIGITS  blink enable per digit.
REQ-011 lz_blank  in  1  leading-zero suppression enable.
REQ-012 bright  in  4  brightness; duty cycle is (bright+1)/16.
REQ-013 load  in  1  one-cycle strobe that captures hex_in, dp_in, blank_in and blink_en.
REQ-014 an  out  NUM_DIGITS  digit enables, one-hot in asserted polarity.
REQ-015 sseg  out  8  segments: bit 7 = dp, bits 6..0 = a..g.
REQ-016 frame_done  out  1  one-cycle pulse when a full scan frame completes.

Function
REQ-017 The prescaler `pre` (DIV_W bits) SHALL increment every cycle and wrap; a slot tick SHALL occur when pre is all ones.
REQ-018 The digit index `idx` SHALL advance on each slot tick, wrapping from NUM_DIGITS-1 to 0; frame_done SHALL pulse in the cycle after that wrap.
REQ-019 On `load`, the inputs SHALL be captured into pending registers; the pending registers SHALL be copied into active registers on each frame boundary (the tick where idx wraps).
REQ-020 If `load` coincides with a frame boundary, the newly loaded values SHALL go directly into both the pending and active registers.
REQ-021 `bright` SHALL be sampled once per slot tick; the sampled value applies to the whole following slot.
REQ-022 The current digit SHALL be lit only while pre[DIV_W-1:DIV_W-4] <= sampled bright.
REQ-023 Under lz_blank=1, digit i (i>0) SHALL be suppressed when active hex of digits i..NUM_DIGITS-1 are all 0 and none of those digits has dp set; digit 0 is never suppressed.
REQ-024 The free-running blink counter's MSB SHALL be the blink phase; while the phase is 1, blink-enabled digits SHALL be dark.
REQ-025 A dark digit (PWM off, blank_in, leading-zero suppressed or blink) SHALL drive all `an` bits inactive and all `sseg` bits inactive.
REQ-026 Glyphs SHALL use the standard hex set 0-9, A, b, C, d, E, F. Active-high a..g values: 0=1111110, 1=0110000, 8=1111111, F=1000111. ACTIVE_LOW inverts them.
REQ-027 `an` and `sseg` SHALL be registered; they reflect the idx/pre state with exactly 1 cycle of latency.
REQ-028 `an` SHALL never have more than one asserted bit in any cycle.

Reset
REQ-029 Asynchronous reset SHALL clear pre, idx, the blink counter, the sampled bright value, the pending registers and the active registers to 0.
REQ-030 During reset, `an` and `sseg` SHALL be all inactive (all ones when ACTIVE_LOW=1) and frame_done SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL discard any pending load; scanning SHALL restart at idx 0 on the first cycle after release.

Structure
REQ-032 The glyph table and the polarity helper constant SHALL live in the shared package `sseg_pkg`.
REQ-033 Hex-to-glyph encoding SHALL be the combinational sub-module `sseg_hex_enc` (4-bit in, 7-bit active-high out).

Verification (NUM_DIGITS=4, DIV_W=5, BLINK_W=8, ACTIVE_LOW=1 unless stated)
REQ-034 Reset, then load hex=0x1238 with bright=15 -> after the next frame boundary, an cycles 1110, 1101, 1011, 0111 every 32 cycles; digit 0 shows sseg=8'b10000000; frame_done pulses every 128 cycles.
REQ-035 bright=3 -> each digit is lit for the first 8 of its 32 cycles, then an=1111 and sseg=8'hFF.
REQ-036 lz_blank=1, load hex=0x0050 with dp=0 -> digits 3 and 2 are dark, digits 1 and 0 show 5 and 0; set dp_in[3]=1 and reload -> all four digits are lit.
REQ-037 Load hex=0xAAAA mid-frame -> the display is unchanged until idx wraps, then shows A on all digits; a load in the same cycle as the boundary takes effect immediately.
REQ-038 blink_en=4'b0001 -> digit 0 is dark for 128 cycles and lit for 128 cycles, alternating; the other digits are unaffected.
REQ-039 Assert reset at idx=2 -> an=1111 and sseg=8'hFF immediately; after release, scanning resumes from idx 0 and the active registers are 0.
